// File: rtl/ranger_pkg.sv
// Shared types and elaboration helpers for the ultrasonic ranger.
package ranger_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        HOLDOFF
    } ranger_state_t;

    // Largest distance representable in a width-bit unsigned field.
    function automatic int unsigned dist_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

    // The period must cover the trigger pulse plus a worst-case echo wait and
    // a worst-case echo, with a few cycles of slack for the pipeline.
    function automatic bit period_is_valid(input longint period_cycles,
                                           input longint trig_cycles,
                                           input longint timeout_cycles);
        return period_cycles > (trig_cycles + 2 * timeout_cycles + 8);
    endfunction

endpackage

// File: rtl/echo_sync.sv
// Brings the raw sensor echo into the clk domain and derives edge strobes.
module echo_sync (
    input  logic clk,
    input  logic reset,
    input  logic echo,
    output logic echo_s,
    output logic rise,
    output logic fall
);

    logic echo_meta;
    logic echo_d;

    // Two-flop synchroniser followed by one delay flop for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            echo_meta <= 1'b0;
            echo_s    <= 1'b0;
            echo_d    <= 1'b0;
        end else begin
            echo_meta <= echo;
            echo_s    <= echo_meta;
            echo_d    <= echo_s;
        end
    end

    assign rise = echo_s & ~echo_d;
    assign fall = ~echo_s & echo_d;

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 front-end: periodic trigger, echo width measurement, cm conversion.
module ultrasonic_ranger
    import ranger_pkg::*;
#(
    parameter int PV_WIDTH            = 9,
    parameter int TRIG_CYCLES         = 1000,
    parameter int CYCLES_PER_CM       = 5800,
    parameter int ECHO_TIMEOUT_CYCLES = 2_500_000,
    parameter int PERIOD_CYCLES       = 6_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                echo,
    output logic                trig,
    output logic [PV_WIDTH-1:0] distance,
    output logic                distance_valid,
    output logic                timeout
);

    localparam int SUB_W = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;
    localparam int TMO_W = (ECHO_TIMEOUT_CYCLES > 1) ? $clog2(ECHO_TIMEOUT_CYCLES) : 1;
    localparam int PER_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;

    localparam logic [PV_WIDTH-1:0] DIST_MAX  = PV_WIDTH'(dist_max(PV_WIDTH));
    localparam logic [SUB_W-1:0]    SUB_LAST  = SUB_W'(CYCLES_PER_CM - 1);
    localparam logic [TMO_W-1:0]    TMO_LAST  = TMO_W'(ECHO_TIMEOUT_CYCLES - 1);
    localparam logic [PER_W-1:0]    TRIG_LAST = PER_W'(TRIG_CYCLES - 1);
    localparam logic [PER_W-1:0]    PER_LAST  = PER_W'(PERIOD_CYCLES - 1);

    if (!period_is_valid(PERIOD_CYCLES, TRIG_CYCLES, ECHO_TIMEOUT_CYCLES)) begin : g_bad_period
        $error("ultrasonic_ranger: PERIOD_CYCLES too short for trigger plus two echo timeouts");
    end

    ranger_state_t       state;
    logic                echo_s;
    logic                rise;
    logic                fall;
    logic                count_en;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [SUB_W-1:0]    sub_cnt;
    logic [PV_WIDTH-1:0] cm_count;
    logic [PER_W-1:0]    period_cnt;

    echo_sync u_echo_sync (
        .clk    (clk),
        .reset  (reset),
        .echo   (echo),
        .echo_s (echo_s),
        .rise   (rise),
        .fall   (fall)
    );

    // The rise cycle is itself the first echo-high cycle, so it is counted too;
    // this makes the total equal the synchronised echo-high width.
    assign count_en = ((state == WAIT_ECHO) && rise) || ((state == MEASURE) && echo_s);

    // Ranging FSM with its counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            trig           <= 1'b0;
            distance       <= '0;
            distance_valid <= 1'b0;
            timeout        <= 1'b0;
            tmo_cnt        <= '0;
            sub_cnt        <= '0;
            cm_count       <= '0;
            period_cnt     <= '0;
        end else begin
            distance_valid <= 1'b0;

            if (count_en) begin
                if (sub_cnt == SUB_LAST) begin
                    sub_cnt <= '0;
                    if (cm_count != DIST_MAX) begin
                        cm_count <= cm_count + 1'b1;
                    end
                end else begin
                    sub_cnt <= sub_cnt + 1'b1;
                end
            end

            if (state != IDLE) begin
                period_cnt <= period_cnt + 1'b1;
            end

            if (state == IDLE) begin
                period_cnt <= '0;
                tmo_cnt    <= '0;
                sub_cnt    <= '0;
                cm_count   <= '0;
            end

            if (!en) begin
                state <= IDLE;
                trig  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= TRIG;
                        trig  <= 1'b1;
                    end
                    TRIG: begin
                        tmo_cnt  <= '0;
                        sub_cnt  <= '0;
                        cm_count <= '0;
                        if (period_cnt == TRIG_LAST) begin
                            state <= WAIT_ECHO;
                            trig  <= 1'b0;
                        end
                    end
                    WAIT_ECHO: begin
                        if (rise) begin
                            state   <= MEASURE;
                            tmo_cnt <= '0;
                        end else if (tmo_cnt == TMO_LAST) begin
                            distance       <= DIST_MAX;
                            timeout        <= 1'b1;
                            distance_valid <= 1'b1;
                            state          <= HOLDOFF;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    MEASURE: begin
                        if (fall) begin
                            distance       <= cm_count;
                            timeout        <= 1'b0;
                            distance_valid <= 1'b1;
                            state          <= HOLDOFF;
                        end else if (tmo_cnt == TMO_LAST) begin
                            distance       <= DIST_MAX;
                            timeout        <= 1'b1;
                            distance_valid <= 1'b1;
                            state          <= HOLDOFF;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    HOLDOFF: begin
                        if (period_cnt == PER_LAST) begin
                            state      <= TRIG;
                            trig       <= 1'b1;
                            period_cnt <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        trig  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
